qtz_seq_mapper: RTL and testbench

QTZ_SEQ_MAPPER -- requirements
Module: qtz_seq_mapper

---
 rtl/qtz_seq_mapper.sv | 162 ++++++++++++++++
 tb/tb_qtz_seq_mapper.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtz_seq_mapper.sv
// rtl/qtz_seq_mapper.sv - quantizes a captured feature vector and streams it out segment by segment with level HVs
module qtz_seq_mapper #(
    parameter int FEATURE_COUNT   = 617,
    parameter int FEATURES_PER_CC = 62,
    parameter int HV_DIM          = 5000,
    parameter int NUM_LEVELS      = 16,
    localparam int LVL_W     = $clog2(NUM_LEVELS),
    localparam int SEG_COUNT = (FEATURE_COUNT + FEATURES_PER_CC - 1) / FEATURES_PER_CC,
    localparam int SEG_W     = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              en,
    input  logic                              start_mapping,
    input  logic                              abort,
    input  logic [FEATURE_COUNT*16-1:0]       input_values,
    input  logic [NUM_LEVELS*HV_DIM-1:0]      im_hvs,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [SEG_W-1:0]                  out_seg,
    output logic [FEATURES_PER_CC-1:0]        out_mask,
    output logic [FEATURES_PER_CC*LVL_W-1:0]  out_levels,
    output logic [FEATURES_PER_CC*HV_DIM-1:0] level_hvs,
    output logic                              busy,
    output logic                              mapping_done
);

    localparam int FC_W = (FEATURE_COUNT > 1) ? $clog2(FEATURE_COUNT) : 1;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(SEG_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    logic [SEG_W-1:0] seg_cnt;
    logic             armed;
    logic             capture;
    logic             load;

    // Only the level bits of each feature matter downstream, so the buffer keeps just those.
    logic [LVL_W-1:0]  lvl_buf [FEATURE_COUNT];
    logic [HV_DIM-1:0] im_arr  [NUM_LEVELS];
    logic              unused_frac_bits;

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_im_split
        assign im_arr[g] = im_hvs[g*HV_DIM +: HV_DIM];
    end

    always_comb begin
        unused_frac_bits = 1'b0;
        for (int f = 0; f < FEATURE_COUNT; f++) begin
            unused_frac_bits = unused_frac_bits ^ (^input_values[16*f +: 16-LVL_W]);
        end
    end

    assign capture = (state == IDLE) && en && start_mapping && !abort;
    assign load    = (state == RUN) && en && armed && (!out_valid || out_ready);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int f = 0; f < FEATURE_COUNT; f++) begin
                lvl_buf[f] <= input_values[16*f+15 -: LVL_W];
            end
        end
    end

    logic [FEATURES_PER_CC-1:0]        nxt_mask;
    logic [FEATURES_PER_CC*LVL_W-1:0]  nxt_levels;
    logic [FEATURES_PER_CC*HV_DIM-1:0] nxt_hvs;
    int                                idx;
    logic [FC_W-1:0]                   fidx;
    logic [LVL_W-1:0]                  lvl;

    // Lanes past the last feature stay all-zero so the consumer can rely on the mask alone.
    always_comb begin
        nxt_mask   = '0;
        nxt_levels = '0;
        nxt_hvs    = '0;
        idx        = 0;
        fidx       = '0;
        lvl        = '0;
        for (int i = 0; i < FEATURES_PER_CC; i++) begin
            idx = int'(seg_cnt) * FEATURES_PER_CC + i;
            if (idx < FEATURE_COUNT) begin
                fidx                             = FC_W'(idx);
                lvl                              = lvl_buf[fidx];
                nxt_mask[i]                      = 1'b1;
                nxt_levels[i*LVL_W +: LVL_W]     = lvl;
                nxt_hvs[i*HV_DIM +: HV_DIM]      = im_arr[lvl];
            end
        end
    end

    // The first RUN cycle only arms the pipe, so the first segment appears two edges after start.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state        <= IDLE;
            seg_cnt      <= '0;
            armed        <= 1'b0;
            out_valid    <= 1'b0;
            mapping_done <= 1'b0;
            out_seg      <= '0;
            out_mask     <= '0;
            out_levels   <= '0;
            level_hvs    <= '0;
        end else begin
            mapping_done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                armed     <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (en && start_mapping) begin
                            seg_cnt <= '0;
                            armed   <= 1'b0;
                            state   <= RUN;
                        end
                    end
                    RUN: begin
                        if (load) begin
                            out_seg    <= seg_cnt;
                            out_mask   <= nxt_mask;
                            out_levels <= nxt_levels;
                            level_hvs  <= nxt_hvs;
                            out_valid  <= 1'b1;
                            seg_cnt    <= seg_cnt + 1'b1;
                            if (seg_cnt == LAST_SEG) begin
                                state <= FLUSH;
                            end
                        end else if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                        end
                        if (en) begin
                            armed <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        // A final handshake taken while en=0 leaves FLUSH with nothing pending until en returns.
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                            if (en) begin
                                state        <= IDLE;
                                mapping_done <= 1'b1;
                            end
                        end else if (!out_valid && en) begin
                            state        <= IDLE;
                            mapping_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qtz_seq_mapper.sv
// tb/tb_qtz_seq_mapper.sv - scoreboard bench for qtz_seq_mapper with a behavioural segment model
module tb_qtz_seq_mapper;

    localparam int FC   = 10;
    localparam int FPC  = 4;
    localparam int HVD  = 8;
    localparam int NL   = 4;
    localparam int SEGS = 3;

    logic             clk = 1'b0;
    logic             nrst = 1'b1;
    logic             en = 1'b0;
    logic             start_mapping = 1'b0;
    logic             abort = 1'b0;
    logic             out_ready = 1'b0;
    logic [FC*16-1:0] input_values = '0;
    logic [NL*HVD-1:0] im_hvs;
    logic             out_valid;
    logic [1:0]       out_seg;
    logic [3:0]       out_mask;
    logic [7:0]       out_levels;
    logic [31:0]      level_hvs;
    logic             busy;
    logic             mapping_done;

    always #5 clk = ~clk;

    qtz_seq_mapper #(
        .FEATURE_COUNT(FC),
        .FEATURES_PER_CC(FPC),
        .HV_DIM(HVD),
        .NUM_LEVELS(NL)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .en(en),
        .start_mapping(start_mapping),
        .abort(abort),
        .input_values(input_values),
        .im_hvs(im_hvs),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_seg(out_seg),
        .out_mask(out_mask),
        .out_levels(out_levels),
        .level_hvs(level_hvs),
        .busy(busy),
        .mapping_done(mapping_done)
    );

    typedef struct {
        int          seg;
        logic [3:0]  mask;
        logic [7:0]  lv;
        logic [31:0] hv;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          hs_cyc[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    bit          done_seen = 0;
    bit          pend_done = 0;
    bit          exp_done_nxt = 0;
    bit          stall_prev = 0;
    bit          rnd_mode = 0;
    logic [45:0] snap = '0;
    logic [15:0] vals [FC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Expected stream straight from the rules: feature f -> segment f/4, lane f%4, level = value/16384.
    task automatic push_model();
        for (int s = 0; s < SEGS; s++) begin
            exp_t e;
            e.seg  = s;
            e.mask = '0;
            e.lv   = '0;
            e.hv   = '0;
            e.last = (s == SEGS - 1);
            for (int i = 0; i < FPC; i++) begin
                int f = s * FPC + i;
                if (f < FC) begin
                    int lev = int'(vals[f]) / 16384;
                    e.mask[i]       = 1'b1;
                    e.lv[i*2 +: 2]  = 2'(lev);
                    e.hv[i*8 +: 8]  = 8'(17 * (lev + 1));
                end
            end
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        if (rnd_mode) begin
            out_ready = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (nrst || abort) begin
            stall_prev = 0;
        end else begin
            if (exp_done_nxt || mapping_done) begin
                chk("mapping_done", 64'(mapping_done), 64'(exp_done_nxt));
                if (mapping_done) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                end
            end
            exp_done_nxt = 0;
            if (stall_prev) begin
                chk("hold_stable", {out_valid, out_seg, out_mask, out_levels, level_hvs}, {1'b1, snap});
            end
            stall_prev = out_valid && !out_ready;
            snap = {out_seg, out_mask, out_levels, level_hvs};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_segment: got seg %0d, required none", out_seg);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("seg%0d_data", mon_e.seg), {out_seg, out_mask, out_levels, level_hvs},
                        {2'(mon_e.seg), mon_e.mask, mon_e.lv, mon_e.hv});
                    hs_cyc.push_back(cyc);
                    if (mon_e.last) pend_done = 1;
                end
            end
            if (pend_done && en) begin
                exp_done_nxt = 1;
                pend_done    = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        hs_cyc.delete();
        pend_done    = 0;
        exp_done_nxt = 0;
        stall_prev   = 0;
        done_seen    = 0;
    endtask

    task automatic rand_vals();
        for (int f = 0; f < FC; f++) begin
            case ($urandom_range(0, 7))
                0: vals[f] = 16'h0000;
                1: vals[f] = 16'hFFFF;
                2: vals[f] = 16'h3FFF;
                3: vals[f] = 16'h4000;
                default: vals[f] = 16'($urandom);
            endcase
        end
    endtask

    task automatic do_start(input bit chk_timing);
        for (int f = 0; f < FC; f++) input_values[16*f +: 16] = vals[f];
        hs_cyc.delete();
        done_seen = 0;
        push_model();
        en            = 1'b1;
        start_mapping = 1'b1;
        tick(1);
        start_mapping = 1'b0;
        if (chk_timing) chk("valid_after_T", 64'(out_valid), 64'd0);
        tick(1);
        if (chk_timing) chk("valid_after_T1", 64'(out_valid), 64'd0);
        tick(1);
        if (chk_timing) chk("valid_after_T2", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done_seen && k < 400) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (!done_seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no mapping_done in %0d cycles, required one", k);
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int l = 0; l < NL; l++) im_hvs[l*HVD +: HVD] = 8'(17 * (l + 1));

        #12;
        chk("rst_ctrl", {out_valid, busy, mapping_done}, 64'd0);
        chk("rst_data", {out_seg, out_mask, out_levels, level_hvs}, 64'd0);
        nrst = 1'b0;
        tick(1);

        // consecutive segments, latency and done timing
        for (int f = 0; f < FC; f++) vals[f] = 16'(f * 16'h1800);
        out_ready = 1'b1;
        do_start(1);
        wait_done();
        chk("hs_count", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) begin
            chk("rate_01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
            chk("rate_12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd1);
            chk("done_lat", 64'(done_cyc - hs_cyc[2]), 64'd1);
        end
        chk("idle_after_done", {busy, out_valid}, 64'd0);
        tick(2);

        // truncation boundaries
        rand_vals();
        vals[0] = 16'hFFFF;
        vals[1] = 16'h3FFF;
        vals[2] = 16'h4000;
        out_ready = 1'b0;
        do_start(0);
        chk("lvl_bounds", 64'(out_levels[5:0]), 64'(6'b01_00_11));
        chk("hv_bounds", 64'(level_hvs[23:0]), 64'h22_11_44);
        out_ready = 1'b1;
        wait_done();
        tick(2);

        // 5-cycle stall on seg 1
        rand_vals();
        out_ready = 1'b1;
        do_start(0);
        tick(1);
        out_ready = 1'b0;
        chk("stall_seg", {out_valid, out_seg}, {1'b1, 2'd1});
        tick(5);
        chk("stall_seg_end", {out_valid, out_seg}, {1'b1, 2'd1});
        out_ready = 1'b1;
        wait_done();
        if (hs_cyc.size() == 3) begin
            chk("stall_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'd6);
            chk("stall_done", 64'(done_cyc - hs_cyc[0]), 64'd8);
        end else begin
            chk("stall_hs_count", 64'(hs_cyc.size()), 64'd3);
        end
        tick(2);

        // en=0 lets the pending handshake finish without a reload
        rand_vals();
        out_ready = 1'b1;
        do_start(0);
        en = 1'b0;
        tick(1);
        chk("en0_no_reload", {busy, out_valid}, {1'b1, 1'b0});
        tick(2);
        chk("en0_hold", {busy, out_valid}, {1'b1, 1'b0});
        en = 1'b1;
        wait_done();
        tick(2);

        // start during RUN and input change after capture
        rand_vals();
        out_ready = 1'b0;
        do_start(0);
        start_mapping = 1'b1;
        input_values  = {5{32'($urandom)}};
        tick(1);
        start_mapping = 1'b0;
        chk("no_restart", {out_valid, out_seg}, {1'b1, 2'd0});
        tick(2);
        out_ready = 1'b1;
        wait_done();
        tick(2);

        // abort in FLUSH while out_valid is high
        rand_vals();
        out_ready = 1'b0;
        do_start(0);
        out_ready = 1'b1;
        tick(2);
        out_ready = 1'b0;
        chk("flush_seg", {out_valid, out_seg}, {1'b1, 2'd2});
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        clear_sb();
        chk("abort_idle", {busy, out_valid, mapping_done}, 64'd0);
        tick(3);
        rand_vals();
        out_ready = 1'b1;
        do_start(1);
        wait_done();
        tick(2);

        // asynchronous reset pulse mid-RUN
        rand_vals();
        out_ready = 1'b1;
        do_start(0);
        #1 nrst = 1'b1;
        #1 chk("rst_mid_run", {busy, out_valid, mapping_done}, 64'd0);
        #1 nrst = 1'b0;
        clear_sb();
        tick(3);
        chk("rst_stays_idle", {busy, out_valid}, 64'd0);
        rand_vals();
        do_start(1);
        wait_done();
        tick(2);

        // random en/out_ready traffic
        for (int r = 0; r < 10; r++) begin
            rand_vals();
            rnd_mode  = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            do_start(0);
            rnd_mode = 1'b1;
            wait_done();
            rnd_mode  = 1'b0;
            en        = 1'b1;
            out_ready = 1'b1;
            tick(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
